// File: rtl/pinmux_pkg.sv
// pinmux_pkg: shared types and helpers for the pad attribute configuration slice.
//   - pad_cfg_state_e : state encoding of the pad attribute write controller
//   - req_id_e        : identifies the software or hardware (sleep) requester
//   - WarlMask()      : writable-bit mask of an attribute word for a given pad type
package pinmux_pkg;

   // Masks are built at this width and truncated by the user to its own attribute width.
   localparam int unsigned MaskDw = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_APPLY = 2'd1,
      ST_DONE  = 2'd2
   } pad_cfg_state_e;

   typedef enum logic {
      REQ_SW = 1'b0,
      REQ_HW = 1'b1
   } req_id_e;

   // Writable attribute bits per pad type; unknown types are fully read-only.
   function automatic logic [MaskDw-1:0] WarlMask(input int pad_type);
      logic [MaskDw-1:0] mask;
      case (pad_type)
         32'sd0:  mask = {MaskDw{1'b1}};
         32'sd1:  mask = 32'h0000_00FF;
         32'sd2:  mask = 32'h0000_000F;
         default: mask = {MaskDw{1'b0}};
      endcase
      return mask;
   endfunction

endpackage

// File: rtl/pad_attr_rr_arb.sv
// pad_attr_rr_arb: two-requester round-robin arbiter.
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   en_i                 arbitration enable (grants only while high)
//   sw_req_i, hw_req_i   requests
//   sw_gnt_o, hw_gnt_o   combinational one-hot grants
// On a tie the requester that was not granted last wins; after reset the
// pointer says "sw was granted last", so hw wins the first tie.
module pad_attr_rr_arb
   import pinmux_pkg::*;
(
   input  logic clk_i,
   input  logic rst_ni,
   input  logic en_i,
   input  logic sw_req_i,
   input  logic hw_req_i,
   output logic sw_gnt_o,
   output logic hw_gnt_o
);

   req_id_e last_gnt_r;
   logic    sw_gnt_s;
   logic    hw_gnt_s;

   // Grant selection: single requester wins outright, ties go to the one not granted last.
   always_comb begin
      sw_gnt_s = 1'b0;
      hw_gnt_s = 1'b0;
      if (en_i) begin
         if (sw_req_i && hw_req_i) begin
            if (last_gnt_r == REQ_SW) begin
               hw_gnt_s = 1'b1;
            end else begin
               sw_gnt_s = 1'b1;
            end
         end else begin
            sw_gnt_s = sw_req_i;
            hw_gnt_s = hw_req_i;
         end
      end else begin
         sw_gnt_s = 1'b0;
         hw_gnt_s = 1'b0;
      end
   end

   // Remember the last granted requester for the next tie.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         last_gnt_r <= REQ_SW;
      end else if (hw_gnt_s) begin
         last_gnt_r <= REQ_HW;
      end else if (sw_gnt_s) begin
         last_gnt_r <= REQ_SW;
      end
   end

   assign sw_gnt_o = sw_gnt_s;
   assign hw_gnt_o = hw_gnt_s;

endmodule

// File: rtl/pad_attr_cfg_ctrl.sv
// pad_attr_cfg_ctrl: holds the attribute word of every pad and serialises
// write requests from a software and a hardware (sleep) requester.
// Ports:
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   sw_req_i/hw_req_i          write requests (held until granted)
//   sw_idx_i/hw_idx_i          target pad index
//   sw_attr_i/hw_attr_i        requested attribute word
//   sw_gnt_o/hw_gnt_o          one-cycle combinational grant (IDLE only)
//   sw_done_o/hw_done_o        one-cycle completion pulse to the granted requester
//   err_o                      qualifies done: index was out of range
//   attr_o                     registered table, pad i at [i*AttrDw +: AttrDw]
//   busy_o                     high whenever a transaction is in progress
// A granted write lands in the table at the grant edge, then the controller
// waits ApplyCycles settling cycles before signalling completion.
module pad_attr_cfg_ctrl
   import pinmux_pkg::*;
#(
   parameter int unsigned NumPads     = 8,
   parameter int unsigned AttrDw      = 13,
   parameter int          PadType     = 0,
   parameter int unsigned ApplyCycles = 4
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        sw_req_i,
   input  logic                        hw_req_i,
   input  logic [$clog2(NumPads):0]    sw_idx_i,
   input  logic [$clog2(NumPads):0]    hw_idx_i,
   input  logic [AttrDw-1:0]           sw_attr_i,
   input  logic [AttrDw-1:0]           hw_attr_i,
   output logic                        sw_gnt_o,
   output logic                        hw_gnt_o,
   output logic                        sw_done_o,
   output logic                        hw_done_o,
   output logic                        err_o,
   output logic [NumPads*AttrDw-1:0]   attr_o,
   output logic                        busy_o
);

   localparam int unsigned    IdxW       = $clog2(NumPads) + 1;
   localparam logic [AttrDw-1:0] WrMask  = AttrDw'(WarlMask(PadType));
   localparam logic [3:0]     ApplyLoad  = 4'(ApplyCycles);

   pad_cfg_state_e            state_r;
   pad_cfg_state_e            state_nxt_s;
   logic [3:0]                cnt_r;
   logic                      err_r;
   req_id_e                   owner_r;
   logic [NumPads*AttrDw-1:0] attr_r;

   logic                      arb_en_s;
   logic                      sw_gnt_s;
   logic                      hw_gnt_s;
   logic                      any_gnt_s;
   logic [IdxW-1:0]           sel_idx_s;
   logic [AttrDw-1:0]         sel_attr_s;
   logic                      idx_ok_s;

   // Gating with rst_ni keeps the grants low while reset is asserted.
   assign arb_en_s  = (state_r == ST_IDLE) && rst_ni;
   assign any_gnt_s = sw_gnt_s || hw_gnt_s;

   pad_attr_rr_arb u_arb (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .en_i     (arb_en_s),
      .sw_req_i (sw_req_i),
      .hw_req_i (hw_req_i),
      .sw_gnt_o (sw_gnt_s),
      .hw_gnt_o (hw_gnt_s)
   );

   // Route the winning requester's index and attribute word.
   always_comb begin
      sel_idx_s  = sw_idx_i;
      sel_attr_s = sw_attr_i;
      if (hw_gnt_s) begin
         sel_idx_s  = hw_idx_i;
         sel_attr_s = hw_attr_i;
      end else begin
         sel_idx_s  = sw_idx_i;
         sel_attr_s = sw_attr_i;
      end
   end

   assign idx_ok_s = (sel_idx_s < IdxW'(NumPads));

   // Next-state logic; APPLY leaves on the last count so it spans ApplyCycles cycles.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (any_gnt_s) begin
               state_nxt_s = ST_APPLY;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_APPLY: begin
            if (cnt_r <= 4'd1) begin
               state_nxt_s = ST_DONE;
            end else begin
               state_nxt_s = ST_APPLY;
            end
         end
         ST_DONE: state_nxt_s = ST_IDLE;
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Transaction context captured at the grant edge, settle counter counted down in APPLY.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_r   <= 4'd0;
         err_r   <= 1'b0;
         owner_r <= REQ_SW;
      end else if (any_gnt_s) begin
         cnt_r   <= ApplyLoad;
         err_r   <= !idx_ok_s;
         owner_r <= hw_gnt_s ? REQ_HW : REQ_SW;
      end else if ((state_r == ST_APPLY) && (cnt_r != 4'd0)) begin
         cnt_r   <= cnt_r - 4'd1;
      end
   end

   // Attribute table: only writable bits take the new value; out-of-range writes are dropped.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         attr_r <= '0;
      end else begin
         for (int i = 0; i < int'(NumPads); i++) begin
            if (any_gnt_s && idx_ok_s && (sel_idx_s == IdxW'(i))) begin
               attr_r[i*AttrDw +: AttrDw] <= (attr_r[i*AttrDw +: AttrDw] & ~WrMask)
                                           | (sel_attr_s & WrMask);
            end
         end
      end
   end

   assign sw_gnt_o  = sw_gnt_s;
   assign hw_gnt_o  = hw_gnt_s;
   assign sw_done_o = (state_r == ST_DONE) && (owner_r == REQ_SW);
   assign hw_done_o = (state_r == ST_DONE) && (owner_r == REQ_HW);
   assign err_o     = (state_r == ST_DONE) && err_r;
   assign busy_o    = (state_r != ST_IDLE);
   assign attr_o    = attr_r;

endmodule

// File: doc/pad_attr_cfg_ctrl.md
PAD_ATTR_CFG_CTRL -- requirements
Module: pad_attr_cfg_ctrl

Interface
REQ-001 SHALL have parameter NumPads, default 8, number of pads whose attributes are held.
REQ-002 SHALL have parameter AttrDw, default 13, width of one pad attribute word.
REQ-003 SHALL have parameter PadType, int, default 0, pad type selecting the writable-attribute mask.
REQ-004 SHALL have parameter ApplyCycles, default 4, range 1..15, settling cycles per write.
REQ-005 SHALL have port clk_i, input, 1, sole clock, rising edge.
REQ-006 SHALL have port rst_ni, input, 1, reset, asynchronous, active-low.
REQ-007 SHALL have ports sw_req_i / hw_req_i, input, 1 each, write request from the software and hardware (sleep) requesters.
REQ-008 SHALL have ports sw_idx_i / hw_idx_i, input, $clog2(NumPads)+1 each, target pad index.
REQ-009 SHALL have ports sw_attr_i / hw_attr_i, input, AttrDw each, requested attribute word.
REQ-010 SHALL have ports sw_gnt_o / hw_gnt_o, output, 1 each, one-cycle grant (request accepted).
REQ-011 SHALL have ports sw_done_o / hw_done_o, output, 1 each, one-cycle completion pulse.
REQ-012 SHALL have port err_o, output, 1, qualifies a done pulse: index was out of range.
REQ-013 SHALL have port attr_o, output, NumPads*AttrDw, registered attribute table, pad i at bits [i*AttrDw +: AttrDw].
REQ-014 SHALL have port busy_o, output, 1, high whenever state is not IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, APPLY, DONE.
REQ-016 IDLE: if any request is high, SHALL assert exactly one grant combinationally in that cycle and transition to APPLY at the next edge; otherwise remain in IDLE.
REQ-017 Grants SHALL be asserted only in IDLE; requesters hold req/idx/attr stable until granted; inputs are sampled only at the grant edge.
REQ-018 Simultaneous requests SHALL be resolved round-robin: the requester not granted last wins; after reset hw wins the first tie.
REQ-019 At the grant edge, for idx < NumPads, the entry SHALL be written with attr & WarlMask(PadType); unmasked bits keep their previous value.
REQ-020 For idx >= NumPads, SHALL leave the table unchanged and set an internal error flag for this transaction.
REQ-021 APPLY SHALL last exactly ApplyCycles cycles, counted by a 4-bit down-counter loaded at the grant edge.
REQ-022 DONE SHALL last one cycle; the granted requester's done_o pulses; err_o equals the error flag in that cycle and is 0 otherwise; next state IDLE.
REQ-023 Latency: grant in cycle t -> attr_o updated from t+1 -> done_o in cycle t+ApplyCycles+1 -> next grant earliest in cycle t+ApplyCycles+2.
REQ-024 Requests arriving while busy SHALL be neither granted nor lost; they are arbitrated on return to IDLE.
REQ-025 Deasserting a request before grant SHALL be legal and cause no action.

Reset
REQ-026 rst_ni low SHALL immediately force: state IDLE, counter 0, attr_o to all zeros, error flag 0, round-robin pointer hw-first.
REQ-027 Reset mid-transaction SHALL abort without a done pulse; all outputs are 0 while rst_ni is low.

Structure
REQ-028 Shared package pinmux_pkg SHALL hold the state enum typedef, the function WarlMask(pad type) returning an AttrDw-wide mask (type 0: all ones; type 1: low 8 bits; type 2: low 4 bits), and a requester-ID enum.
REQ-029 The round-robin arbiter for two requesters SHALL be one sub-module, pad_attr_rr_arb.

Verification
REQ-030 Single write: PadType=0, sw write idx=3, attr=0x1ABC -> sw_gnt same cycle, pad 3 entry = 0x1ABC next cycle, sw_done 5 cycles after grant, err_o=0.
REQ-031 Tie: sw and hw both request from reset -> hw granted first, sw granted in the cycle after hw_done+1; repeated ties alternate.
REQ-032 Masking: PadType=2, pad 0 = 0x1FF0, write attr=0x0005 -> pad 0 = 0x1FF5.
REQ-033 Out-of-range: idx=8 with NumPads=8 -> table unchanged, done pulse with err_o=1.
REQ-034 Busy: hw request raised during APPLY -> no hw_gnt until IDLE, then granted; busy_o high throughout.
REQ-035 Reset mid-APPLY: rst_ni low during APPLY cycle 2 -> no done pulse, attr_o=0, state IDLE, next tie grants hw.
